code_loader: RTL and testbench



---
 rtl/code_loader_pkg.sv | 19 +
 rtl/code_loader.sv | 163 ++++++++++++++++
 tb/tb_code_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/code_loader_pkg.sv
// Shared definitions for the code loader and the CPU fetch side.
package code_loader_pkg;

    localparam int unsigned CODE_WIDTH_DEF = 13;

    // Instruction the CPU substitutes while held in reset.
    localparam logic [15:0] NOP_INSTR = 16'd19456;

    typedef enum logic [2:0] {
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/code_loader.sv
// Byte-stream code image loader: writes little-endian words to code memory from address 0.
// Optional trailing XOR checksum byte enabled by CODE_LOADER_CHECKSUM_EN.
module code_loader
    import code_loader_pkg::*;
#(
    parameter int unsigned CODE_WIDTH = CODE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  code_we,
    output logic [CODE_WIDTH-1:0] code_waddr,
    output logic [15:0]           code_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  err
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << CODE_WIDTH;

`ifdef CODE_LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_DATA = ST_CHK;
`else
    localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

    state_t                r_state;
    state_t                w_state_nx;
    logic [7:0]            r_len_lo;
    logic [7:0]            r_lo;
    logic [15:0]           r_remain;
    logic [CODE_WIDTH-1:0] r_widx;
`ifdef CODE_LOADER_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    logic                  r_in_ready, r_we, r_cpu_reset, r_done, r_err;
    logic [CODE_WIDTH-1:0] r_waddr;
    logic [15:0]           r_wdata;

    logic                  w_in_ready_nx, w_we_nx, w_cpu_reset_nx, w_done_nx, w_err_nx;
    logic [CODE_WIDTH-1:0] w_waddr_nx;
    logic [15:0]           w_wdata_nx;

    logic                  w_accept;
    logic                  w_restart;
    logic [15:0]           w_len;

    assign w_accept  = in_valid && r_in_ready;
    assign w_restart = reload && ((r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_len     = {in_data, r_len_lo};

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_LEN_LO;
            r_in_ready  <= 1'b1;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_in_ready  <= w_in_ready_nx;
            r_we        <= w_we_nx;
            r_waddr     <= w_waddr_nx;
            r_wdata     <= w_wdata_nx;
            r_cpu_reset <= w_cpu_reset_nx;
            r_done      <= w_done_nx;
            r_err       <= w_err_nx;
        end
    end

    // Next state and next output values
    always_comb begin
        w_state_nx = r_state;
        w_we_nx    = 1'b0;
        w_waddr_nx = r_waddr;
        w_wdata_nx = r_wdata;
        case (r_state)
            ST_LEN_LO: if (w_accept) w_state_nx = ST_LEN_HI;
            ST_LEN_HI: begin
                if (w_accept) begin
                    if (w_len == 16'd0)
                        w_state_nx = ST_AFTER_DATA;
                    else if ({1'b0, w_len} > MAX_WORDS)
                        w_state_nx = ST_ERR;
                    else
                        w_state_nx = ST_DATA_LO;
                end
            end
            ST_DATA_LO: if (w_accept) w_state_nx = ST_DATA_HI;
            ST_DATA_HI: begin
                if (w_accept) begin
                    w_we_nx    = 1'b1;
                    w_waddr_nx = r_widx;
                    w_wdata_nx = {in_data, r_lo};
                    w_state_nx = (r_remain == 16'd1) ? ST_AFTER_DATA : ST_DATA_LO;
                end
            end
            ST_CHK: begin
`ifdef CODE_LOADER_CHECKSUM_EN
                if (w_accept) w_state_nx = (in_data == r_csum) ? ST_DONE : ST_ERR;
`else
                w_state_nx = ST_ERR;
`endif
            end
            ST_DONE, ST_ERR: if (reload) w_state_nx = ST_LEN_LO;
            default: w_state_nx = ST_LEN_LO;
        endcase
        w_in_ready_nx  = (w_state_nx != ST_DONE) && (w_state_nx != ST_ERR);
        // CPU released one cycle after DONE is entered, so the last write lands first
        w_done_nx      = (r_state == ST_DONE) && (w_state_nx == ST_DONE);
        w_cpu_reset_nx = !w_done_nx;
        w_err_nx       = (w_state_nx == ST_ERR);
    end

    // Byte assembly, word counting and checksum
    always_ff @(posedge clk) begin
        if (reset || w_restart) begin
            r_len_lo <= '0;
            r_lo     <= '0;
            r_remain <= '0;
            r_widx   <= '0;
`ifdef CODE_LOADER_CHECKSUM_EN
            r_csum   <= '0;
`endif
        end else if (w_accept) begin
            case (r_state)
                ST_LEN_LO: r_len_lo <= in_data;
                ST_LEN_HI: r_remain <= w_len;
                ST_DATA_LO: begin
                    r_lo <= in_data;
`ifdef CODE_LOADER_CHECKSUM_EN
                    r_csum <= r_csum ^ in_data;
`endif
                end
                ST_DATA_HI: begin
                    r_remain <= r_remain - 16'd1;
                    r_widx   <= r_widx + CODE_WIDTH'(1);
`ifdef CODE_LOADER_CHECKSUM_EN
                    r_csum   <= r_csum ^ in_data;
`endif
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign code_we    = r_we;
    assign code_waddr = r_waddr;
    assign code_wdata = r_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_code_loader.sv
// Randomized self-checking bench for code_loader against a stream-parsing reference model.
module tb_code_loader;

    localparam int unsigned CW = 13;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic          clk = 1'b0;
    logic          reset, in_valid, reload, in_ready;
    logic [7:0]    in_data;
    logic          code_we, cpu_reset, done, err;
    logic [CW-1:0] code_waddr;
    logic [15:0]   code_wdata;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    int  fall_cyc = 0;
    int  last_acc_cyc = 0;
    logic prev_rst = 1'b1;
    wq_t got;

    code_loader #(.CODE_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .reload(reload), .code_we(code_we),
        .code_waddr(code_waddr), .code_wdata(code_wdata),
        .cpu_reset(cpu_reset), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write capture and CPU release timing, sampled mid-cycle
    always @(negedge clk) begin
        if (code_we) got.push_back({16'(code_waddr), code_wdata});
        if (prev_rst && !cpu_reset) fall_cyc = cyc;
        prev_rst = cpu_reset;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Reference: parse the stream into the list of writes and the final outcome
    task automatic model(input bq_t s, output wq_t w, output bit e_done, output bit e_err);
        int n;
        logic [7:0] x;
        w = {};
        x = 8'h00;
        e_done = 1'b0;
        e_err  = 1'b0;
        n = int'({s[1], s[0]});
        if (n > (1 << CW)) begin
            e_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            w.push_back({16'(i), s[3+2*i], s[2+2*i]});
            x = x ^ s[2+2*i] ^ s[3+2*i];
        end
`ifdef CODE_LOADER_CHECKSUM_EN
        e_done = (s[2+2*n] == x);
        e_err  = !e_done;
`else
        e_done = 1'b1;
`endif
    endtask

    function automatic bq_t make_img(input int n);
        bq_t s;
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            s.push_back(b);
            x = x ^ b;
        end
`ifdef CODE_LOADER_CHECKSUM_EN
        s.push_back(x);
`endif
        return s;
    endfunction

    // Drive bytes with optional bubbles and stray reload pulses (ignored while loading)
    task automatic send(input bq_t s, input bit gaps);
        foreach (s[i]) begin
            bit ok;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = s[i];
            reload   = gaps && ($urandom_range(0, 7) == 0);
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                ok = in_ready;
                @(posedge clk);
                #1;
            end
            reload = 1'b0;
            if (!ok) begin
                check("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            last_acc_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_img(input string tag, input bq_t s, input bit gaps);
        wq_t w;
        bit ed, ee;
        int base, bad;
        base = got.size();
        model(s, w, ed, ee);
        send(s, gaps);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_nwr"}, 32'(got.size() - base), 32'(w.size()));
        bad = 0;
        foreach (w[i]) if (base + i >= got.size() || got[base+i] !== w[i]) bad++;
        check({tag, "_wr"}, 32'(bad), 32'd0);
        check({tag, "_done"}, 32'(done), 32'(ed));
        check({tag, "_err"}, 32'(err), 32'(ee));
        check({tag, "_cpurst"}, 32'(cpu_reset), 32'(!ed));
        check({tag, "_rdy"}, 32'(in_ready), 32'd0);
        if (ed) check({tag, "_fall"}, 32'(fall_cyc), 32'(last_acc_cyc + 1));
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        check("rl_cpurst", 32'(cpu_reset), 32'd1);
        check("rl_done", 32'(done), 32'd0);
        check("rl_err", 32'(err), 32'd0);
        check("rl_rdy", 32'(in_ready), 32'd1);
    endtask

    initial begin
        bq_t s;
        int base;
        reset = 1'b1; in_valid = 1'b0; reload = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 32'(in_ready), 32'd1);
        check("rst_we", 32'(code_we), 32'd0);
        check("rst_waddr", 32'(code_waddr), 32'd0);
        check("rst_wdata", 32'(code_wdata), 32'd0);
        check("rst_cpurst", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;

        // Two-word image
        s = {8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
`ifdef CODE_LOADER_CHECKSUM_EN
        s.push_back(8'h40);
`endif
        base = got.size();
        run_img("two", s, 1'b0);
        check("two_w0", got[base], {16'h0000, 16'h1234});
        check("two_w1", got[base+1], {16'h0001, 16'hABCD});

        // Bytes offered while not ready are not consumed
        base = got.size();
        in_valid = 1'b1; in_data = 8'h55;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("stall_done", 32'(done), 32'd1);
        check("stall_nwr", 32'(got.size() - base), 32'd0);
        pulse_reload();

        // Empty image
        s = {8'h00, 8'h00};
`ifdef CODE_LOADER_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        run_img("n0", s, 1'b0);
        pulse_reload();

        // Oversized image
        s = {8'h01, 8'h20};
        run_img("big", s, 1'b0);
        pulse_reload();

`ifdef CODE_LOADER_CHECKSUM_EN
        s = {8'h01, 8'h00, 8'hFF, 8'h00, 8'h00};
        base = got.size();
        run_img("badcs", s, 1'b0);
        check("badcs_w0", got[base], {16'h0000, 16'h00FF});
        pulse_reload();
`endif

        for (int k = 0; k < 6; k++) begin
            s = make_img($urandom_range(1, 24));
`ifdef CODE_LOADER_CHECKSUM_EN
            if (k % 3 == 2) s[s.size()-1] = s[s.size()-1] ^ 8'h5A;
`endif
            run_img("rnd", s, 1'b1);
            pulse_reload();
        end

        // Full-capacity image; the final write must land at the top address
        s = make_img(1 << CW);
        run_img("full", s, 1'b1);
        check("full_last", 32'(got[got.size()-1] >> 16), 32'h1FFF);
        pulse_reload();

        // Reset between LO and HI of word 3, then a fresh load
        s = make_img(5);
        while (s.size() > 9) void'(s.pop_back());
        send(s, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_we", 32'(code_we), 32'd0);
        check("mid_waddr", 32'(code_waddr), 32'd0);
        check("mid_cpurst", 32'(cpu_reset), 32'd1);
        check("mid_rdy", 32'(in_ready), 32'd1);
        check("mid_done", 32'(done), 32'd0);
        reset = 1'b0;
        run_img("fresh", make_img(4), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
